serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial N-bit subtractor built around the existing one-bit full-subtractor cell. It accepts two WIDTH-bit operands on a start pulse and feeds them to the cell LSB first, one bit per clock. A registered borrow closes the loop between cycles, and the cell's difference bits are collected into a parallel result. It sits directly around the one-bit cell: it drives the cell's A/B/bIn inputs and consumes its D/bOut outputs.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high while a subtraction is in progress (SHIFT state).
- done  output  1  one-cycle pulse when diff/borrow_out are valid.
- diff  output  WIDTH  a - b mod 2^WIDTH; held until the next accepted start.
- borrow_out  output  1  final borrow (1 when a < b unsigned); held with diff.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on start=1.
  - SHIFT -> DONE when bit count reaches WIDTH-1 and that bit is processed.
  - DONE -> IDLE unconditionally after one cycle.
- Accepted start (IDLE only):
  - load a_sr<=a and b_sr<=b.
  - clear borrow register and bit counter.
  - clear diff, borrow_out and ovf.
- Each SHIFT cycle:
  - cell inputs are A=a_sr[0], B=b_sr[0], bIn=borrow reg.
  - a_sr and b_sr shift right by one.
  - cell D shifts into diff at the MSB, so diff shifts right.
  - borrow reg <= cell bOut; counter increments.
- After exactly WIDTH shifts, diff holds the full result LSB-aligned.
- DONE:
  - borrow_out <= borrow reg.
  - done=1 for exactly this one cycle.
- start in SHIFT or DONE is ignored; it is neither queued nor allowed to corrupt the operands.
- a/b may change freely after the accept cycle.
- Counter width: $clog2(WIDTH). Terminal count: WIDTH-1. No wrap-around beyond it.

## Timing
- Reset values:
  - state IDLE.
  - busy=0, done=0, diff=0, borrow_out=0, ovf=0.
  - shift registers, borrow reg and counter all 0.
- rst mid-operation aborts immediately. done is not pulsed, and outputs return to their reset values.
- busy rises on the clock edge that accepts start and falls on entry to DONE.
- Latency: start sampled at edge 0 gives diff final after edge WIDTH; done and borrow_out are valid after edge WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. Earliest next accept is the edge after DONE.
- diff is visible in partially shifted form while busy=1. Consumers must sample on done.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - adds the ovf port and a sign capture register.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), registered in DONE alongside borrow_out.
  - ovf holds until the next accepted start or reset.
- Undefined: no ovf port and no sign register. All other behaviour is identical.

## Structure
- Shared header serial_sub_pkg.vh holds:
  - state encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - the default WIDTH constant.
- One sub-module: the existing one-bit cell fullSubtract, instantiated once, purely combinational.
- All sequencing, borrow storage and shifting live in serial_subtractor.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, start pulsed one cycle -> busy for 8 cycles; done one cycle at edge 9; diff=0x37, borrow_out=0.
- a=0x10, b=0x20 -> diff=0xF0, borrow_out=1. Repeat a=0x00, b=0x00 -> diff=0x00, borrow_out=0.
- a=0xFF, b=0x01, then start held high for 20 cycles -> first result diff=0xFE. A second operation starts only from IDLE, with no restart while busy; done pulses never overlap.
- Start a=0x5A, b=0x23; assert rst asynchronously at cycle 4 -> outputs drop to 0 immediately, no done pulse. Fresh start after release gives the correct 0x37.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1. a=0x05, b=0x03 -> diff=0x02, ovf=0.
- Exhaustive sweep at WIDTH=4 (256 pairs) against a behavioural a-b model, checking diff, borrow_out and done timing on each.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings, default width
// and the signed-overflow rule used when SERIAL_SUB_OVF_EN is defined.
package serial_sub_pkg;

  localparam int SERIAL_SUB_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Overflow occurs when the operand signs differ and the result sign differs from the minuend sign.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_fullsub.sv
// One-bit full-subtractor cell: D = A - B - bIn, with borrow out.
module fullSubtract (
  input  logic A,
  input  logic B,
  input  logic bIn,
  output logic D,
  output logic bOut
);

  assign D    = A ^ B ^ bIn;
  assign bOut = (~A & B) | (~(A ^ B) & bIn);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor wrapped around the fullSubtract cell, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic             r_borrow_out;
  logic             r_done;
  logic             w_d;
  logic             w_bout;

  fullSubtract u_cell (
    .A    (r_a_sr[0]),
    .B    (r_b_sr[0]),
    .bIn  (r_borrow),
    .D    (w_d),
    .bOut (w_bout)
  );

`ifdef SERIAL_SUB_OVF_EN
  // Operand signs are shifted out of a_sr/b_sr, so keep them for the DONE-time check.
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
      r_ovf   <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_ovf   <= sub_ovf(r_a_msb, r_b_msb, r_diff[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_a_sr       <= '0;
      r_b_sr       <= '0;
      r_diff       <= '0;
      r_cnt        <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sr       <= a;
            r_b_sr       <= b;
            r_diff       <= '0;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
            r_state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_diff   <= {w_d, r_diff[WIDTH-1:1]};
          r_borrow <= w_bout;
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_borrow_out <= r_borrow;
          r_done       <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state == ST_SHIFT);
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule
